// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package mem_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int STRB_WIDTH = XLEN / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWNER_IFETCH,
        OWNER_DATA
    } arb_owner_e;

    typedef struct packed {
        logic                  we;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. valid[0] is instruction fetch, valid[1] is data;
// on a tie the requester that did not win last time is granted.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  arb_owner_e last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] && (!valid[1] || (last_owner == OWNER_DATA));
        grant[1] = valid[1] && (!valid[0] || (last_owner == OWNER_IFETCH));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one outstanding request at a time, with round-robin arbitration.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | arbitrate between valids, accept one request and latch it
// ARB_REQ  | hold the latched request on mem_req_* until mem_req_ready
// ARB_WAIT | wait for mem_rsp_valid and route it to the latched owner
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [XLEN-1:0]       if_req_addr,
    output logic                  if_rsp_valid,
    output logic [XLEN-1:0]       if_rsp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_req_we,
    input  logic [XLEN-1:0]       d_req_addr,
    input  logic [XLEN-1:0]       d_req_wdata,
    input  logic [STRB_WIDTH-1:0] d_req_wstrb,
    output logic                  d_rsp_valid,
    output logic [XLEN-1:0]       d_rsp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [XLEN-1:0]       mem_req_addr,
    output logic [XLEN-1:0]       mem_req_wdata,
    output logic [STRB_WIDTH-1:0] mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,

    output logic                  protocol_err
);

    arb_state_e state, next_state;
    arb_owner_e last_owner;
    arb_owner_e owner;
    mem_req_t   req;
    logic [1:0] grant;
    logic       accept_if;
    logic       accept_d;

    rr_arbiter2 u_rr (
        .valid      ({d_req_valid, if_req_valid}),
        .last_owner (last_owner),
        .grant      (grant)
    );

    always_comb begin
        next_state = state;
        accept_if  = 1'b0;
        accept_d   = 1'b0;
        case (state)
            ARB_IDLE: begin
                accept_if = grant[0];
                accept_d  = grant[1];
                if (grant[0] || grant[1]) next_state = ARB_REQ;
            end
            ARB_REQ:  if (mem_req_ready) next_state = ARB_WAIT;
            ARB_WAIT: if (mem_rsp_valid) next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= ARB_IDLE;
            last_owner   <= OWNER_IFETCH;
            owner        <= OWNER_IFETCH;
            req          <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= next_state;
            if (accept_if) begin
                last_owner <= OWNER_IFETCH;
                owner      <= OWNER_IFETCH;
                req.we     <= 1'b0;
                req.addr   <= if_req_addr;
                req.wdata  <= '0;
                req.wstrb  <= '0;
            end else if (accept_d) begin
                last_owner <= OWNER_DATA;
                owner      <= OWNER_DATA;
                req.we     <= d_req_we;
                req.addr   <= d_req_addr;
                req.wdata  <= d_req_wdata;
                req.wstrb  <= d_req_wstrb;
            end
            if (mem_rsp_valid && (state != ARB_WAIT)) protocol_err <= 1'b1;
        end
    end

    // Handshake outputs are masked while n_rst is low so nothing is accepted
    // or delivered in a cycle whose state is about to be discarded.
    assign if_req_ready = n_rst && (state == ARB_IDLE) && grant[0];
    assign d_req_ready  = n_rst && (state == ARB_IDLE) && grant[1];

    assign mem_req_valid = (state == ARB_REQ);
    assign mem_req_we    = req.we;
    assign mem_req_addr  = req.addr;
    assign mem_req_wdata = req.wdata;
    assign mem_req_wstrb = req.wstrb;

    assign if_rsp_valid = n_rst && mem_rsp_valid && (state == ARB_WAIT) && (owner == OWNER_IFETCH);
    assign d_rsp_valid  = n_rst && mem_rsp_valid && (state == ARB_WAIT) && (owner == OWNER_DATA);
    assign if_rsp_data  = mem_rsp_data;
    assign d_rsp_data   = mem_rsp_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the core's instruction-fetch requester and its load/store requester. Accepts one request at a time from either side over valid/ready, forwards it to the memory with a held request, waits for the memory's response, and routes the response back to the originating requester. Sits between the core and the unified RAM, replacing the core's separate instruction and data ports.

## Interface
- XLEN, 32, data and address width
- STRB_WIDTH, XLEN/8, byte-strobe width

- clk  in  1  clock
- n_rst  in  1  synchronous, active-low reset
- if_req_valid  in  1  fetch request; always a read
- if_req_ready  out  1  fetch request accepted this cycle when both are high
- if_req_addr  in  XLEN  fetch address
- if_rsp_valid  out  1  fetch response strobe, one cycle
- if_rsp_data  out  XLEN  fetched instruction
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle when both are high
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  XLEN  data address
- d_req_wdata  in  XLEN  store data
- d_req_wstrb  in  STRB_WIDTH  store byte enables
- d_rsp_valid  out  1  data response strobe, one cycle; issued for loads and stores
- d_rsp_data  out  XLEN  load data; equals mem_rsp_data, and is meaningless for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb  out  1/XLEN/XLEN/STRB_WIDTH  registered request fields
- mem_rsp_valid  in  1  memory response; exactly one per accepted request, for reads and writes
- mem_rsp_data  in  XLEN  read data
- protocol_err  out  1  sticky flag: mem_rsp_valid seen outside ARB_WAIT

## Operation
- The FSM has three states:
  - ARB_IDLE: grant is computed from the valids. On acceptance, latch addr, we, wdata, wstrb and owner, then go to ARB_REQ.
  - ARB_REQ: mem_req_valid = 1 from the latched fields, held stable. On mem_req_ready, go to ARB_WAIT.
  - ARB_WAIT: on mem_rsp_valid, go to ARB_IDLE.
- Fetch requests are latched with we = 0 and wstrb = 0.
- Arbitration is round-robin on the last_owner register:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_owner wins.
  - last_owner updates on acceptance. Its reset value is OWNER_IFETCH, so the first tie goes to data.
- Ready rules:
  - if_req_ready = (state == ARB_IDLE) && grant_if.
  - d_req_ready = (state == ARB_IDLE) && grant_d.
  - At most one ready is high per cycle. Ready may depend combinationally on the valids.
- Response routing:
  - rsp_valid = mem_rsp_valid && state == ARB_WAIT && owner match.
  - Response data passes through combinationally from mem_rsp_data.
- A requester must hold valid and its fields stable until accepted. The arbiter never drops a granted request.
- mem_rsp_valid in ARB_IDLE or ARB_REQ is ignored (not routed) and sets protocol_err. protocol_err is cleared only by reset.
- The memory may deassert mem_req_ready for any number of cycles. The arbiter has no timeout.

## Timing
- Reset values:
  - state = ARB_IDLE, last_owner = OWNER_IFETCH, protocol_err = 0.
  - Latched fields = 0.
  - Consequently all ready, valid and rsp_valid outputs are 0 during reset.
- Reset during ARB_REQ or ARB_WAIT abandons the transaction: mem_req_valid drops on the next edge and no rsp_valid is issued.
- Best-case timeline:
  - Cycle 0: accept.
  - Cycle 1: mem_req_valid, with mem_req_ready = 1.
  - Cycle 2: mem_rsp_valid, and rsp_valid to the requester in the same cycle.
  - Cycle 3: ARB_IDLE, next acceptance possible.
- Minimum spacing between acceptances is 3 cycles. Requester-visible latency is 2 cycles plus memory stalls.
- Memory response must arrive no earlier than the cycle after mem_req_ready. A same-cycle response arrives in ARB_REQ and counts as a protocol error.

## Structure
- riscv_pkg additions:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT}.
  - arb_owner_e (1 bit) {OWNER_IFETCH, OWNER_DATA}.
  - mem_req_t struct {we, addr, wdata, wstrb}, used for the latched request.
- Sub-module rr_arbiter2: combinational two-way round-robin grant from (valid[1:0], last_owner).

## Test plan
- Single fetch: if_req_addr = 0x100, memory responds 0x00500093 two cycles after grant -> if_req_ready in cycle 0, mem_req_addr = 0x100 and we = 0 in cycle 1, if_rsp_valid with data 0x00500093 in cycle 2, d_rsp_valid never high.
- Store: addr 0x200, wdata 0xDEADBEEF, wstrb 0xF, mem_req_ready held low 3 cycles -> mem_req fields stable through all 4 cycles of ARB_REQ, one d_rsp_valid after the response.
- Contention: both valid continuously from reset -> grant order D, IF, D, IF over 4 transactions, with no cycle where both readys are high.
- Protocol error: pulse mem_rsp_valid in ARB_IDLE -> protocol_err rises next cycle and stays 1, no rsp_valid is issued, and normal transactions still complete.
- Reset mid-operation: assert n_rst low in ARB_WAIT -> mem_req_valid = 0, state ARB_IDLE and last_owner = OWNER_IFETCH after the edge; the first tie after reset grants data.
